// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - frame-synchronous video test-pattern source with valid/ready pixel output
module video_pattern_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int BPC         = 8,
    parameter int CHECK_SHIFT = 5,
    parameter int FCNT_W      = 16
) (
    input  logic                i_clk_pixel,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic [1:0]          i_mode,
    input  logic [3*BPC-1:0]    i_color,
    output logic [3*BPC-1:0]    o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_sof,
    output logic                o_eol,
    output logic                o_busy,
    output logic [FCNT_W-1:0]   o_frame_cnt
);
    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BW = H_ACTIVE / 8;
    localparam int DW = 3 * BPC;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [XW-1:0]       x_q, x_d, cnt_q, cnt_d;
    logic [YW-1:0]       y_q, y_d;
    logic [2:0]          bar_q, bar_d;
    logic [1:0]          mode_q, mode_d;
    logic [DW-1:0]       color_q, color_d, data_q, data_d;
    logic                sof_q, sof_d, eol_q, eol_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

    logic                last_x, last_y, start;
    logic [XW-1:0]       nx, ncnt;
    logic [YW-1:0]       ny;
    logic [2:0]          nbar;

    // Bar colour bits per index: R=~bar[1], G=~bar[2], B=~bar[0] gives W,Y,C,G,M,R,B,K.
    function automatic logic [DW-1:0] pixel(input logic [1:0] m, input logic [DW-1:0] c,
                                            input logic [XW-1:0] px, input logic [YW-1:0] py,
                                            input logic [2:0] bar);
        logic [BPC-1:0] ramp;
        logic           cb;
        ramp = BPC'(px);
        cb   = 1'(px >> CHECK_SHIFT) ^ 1'(py >> CHECK_SHIFT);
        case (m)
            2'd0:    pixel = c;
            2'd1:    pixel = {{BPC{~bar[1]}}, {BPC{~bar[2]}}, {BPC{~bar[0]}}};
            2'd2:    pixel = {ramp, ramp, ramp};
            default: pixel = {DW{cb}};
        endcase
    endfunction

    always_comb begin
        last_x = (x_q == XW'(H_ACTIVE - 1));
        last_y = (y_q == YW'(V_ACTIVE - 1));
        nx     = last_x ? '0 : x_q + XW'(1);
        ny     = last_x ? y_q + YW'(1) : y_q;
        if (last_x) begin
            nbar = 3'd0;
            ncnt = '0;
        end else if (cnt_q == XW'(BW - 1) && bar_q != 3'd7) begin
            nbar = bar_q + 3'd1;
            ncnt = '0;
        end else begin
            nbar = bar_q;
            ncnt = cnt_q + XW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        bar_d   = bar_q;
        mode_d  = mode_q;
        color_d = color_q;
        data_d  = data_q;
        sof_d   = sof_q;
        eol_d   = eol_q;
        fcnt_d  = fcnt_q;
        start   = 1'b0;
        case (state_q)
            IDLE: start = i_enable;
            RUN: begin
                if (i_ready) begin
                    if (last_x && last_y) begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
                        if (i_enable) begin
                            start = 1'b1;
                        end else begin
                            state_d = IDLE;
                            x_d     = '0;
                            y_d     = '0;
                            data_d  = '0;
                            sof_d   = 1'b0;
                            eol_d   = 1'b0;
                        end
                    end else begin
                        x_d    = nx;
                        y_d    = ny;
                        cnt_d  = ncnt;
                        bar_d  = nbar;
                        data_d = pixel(mode_q, color_q, nx, ny, nbar);
                        sof_d  = 1'b0;
                        eol_d  = (nx == XW'(H_ACTIVE - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Frame start relatches mode/colour and preloads pixel (0,0).
        if (start) begin
            state_d = RUN;
            mode_d  = i_mode;
            color_d = i_color;
            x_d     = '0;
            y_d     = '0;
            cnt_d   = '0;
            bar_d   = 3'd0;
            data_d  = pixel(i_mode, i_color, '0, '0, 3'd0);
            sof_d   = 1'b1;
            eol_d   = 1'b0;
        end
    end

    always_ff @(posedge i_clk_pixel or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            bar_q   <= 3'd0;
            mode_q  <= 2'd0;
            color_q <= '0;
            data_q  <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            bar_q   <= bar_d;
            mode_q  <= mode_d;
            color_q <= color_d;
            data_q  <= data_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = (state_q == RUN);
    assign o_busy      = (state_q == RUN);
    assign o_sof       = sof_q;
    assign o_eol       = eol_q;
    assign o_frame_cnt = fcnt_q;
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb/tb_video_pattern_gen.sv - directed self-checking bench for video_pattern_gen
module tb_video_pattern_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, ready = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [23:0] color = 24'h0;
    logic [23:0] data;
    logic        valid, sof, eol, busy;
    logic [15:0] fcnt;

    logic        en16 = 1'b0, en19 = 1'b0, en300 = 1'b0, one = 1'b1;
    logic [1:0]  m_bar = 2'd1, m_ramp = 2'd2;
    logic [23:0] d16, d19, d300;
    logic        v16, v19, v300, s16, s19, s300, e16, e19, e300, b16, b19, b300;
    logic [15:0] f16, f19, f300;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    video_pattern_gen #(.H_ACTIVE(8), .V_ACTIVE(4), .BPC(8), .CHECK_SHIFT(1), .FCNT_W(16)) dut (
        .i_clk_pixel(clk), .i_rst(rst), .i_enable(en), .i_mode(mode), .i_color(color),
        .o_data(data), .o_valid(valid), .i_ready(ready), .o_sof(sof), .o_eol(eol),
        .o_busy(busy), .o_frame_cnt(fcnt));

    video_pattern_gen #(.H_ACTIVE(16), .V_ACTIVE(2)) dut16 (
        .i_clk_pixel(clk), .i_rst(rst), .i_enable(en16), .i_mode(m_bar), .i_color(color),
        .o_data(d16), .o_valid(v16), .i_ready(one), .o_sof(s16), .o_eol(e16),
        .o_busy(b16), .o_frame_cnt(f16));

    video_pattern_gen #(.H_ACTIVE(19), .V_ACTIVE(2)) dut19 (
        .i_clk_pixel(clk), .i_rst(rst), .i_enable(en19), .i_mode(m_bar), .i_color(color),
        .o_data(d19), .o_valid(v19), .i_ready(one), .o_sof(s19), .o_eol(e19),
        .o_busy(b19), .o_frame_cnt(f19));

    video_pattern_gen #(.H_ACTIVE(300), .V_ACTIVE(2)) dut300 (
        .i_clk_pixel(clk), .i_rst(rst), .i_enable(en300), .i_mode(m_ramp), .i_color(color),
        .o_data(d300), .o_valid(v300), .i_ready(one), .o_sof(s300), .o_eol(e300),
        .o_busy(b300), .o_frame_cnt(f300));

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; ready = 1'b1; en16 = 1'b0; en19 = 1'b0; en300 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!valid) begin
            errors++;
            $display("FAIL %s_start: o_valid=%b after %0d cycles, want 1", name, valid, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({valid, sof, eol, busy, data, fcnt} !== 44'h0) begin
            errors++;
            $display("FAIL reset: valid=%b sof=%b eol=%b busy=%b data=%h fcnt=%0d, want all 0",
                     valid, sof, eol, busy, data, fcnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_solid();
        do_reset();
        mode = 2'd0; color = 24'h112233; ready = 1'b1; en = 1'b1;
        @(negedge clk);
        checks++;
        if (!(valid && sof)) begin
            errors++;
            $display("FAIL solid_latency: valid=%b sof=%b, want 1 1", valid, sof);
        end
        for (int t = 0; t < 64; t++) begin
            checks++;
            if ({valid, sof, eol, data} !== {1'b1, (t % 32) == 0, (t % 8) == 7, 24'h112233}) begin
                errors++;
                $display("FAIL solid t=%0d: valid=%b sof=%b eol=%b data=%h, want 1 %b %b 112233",
                         t, valid, sof, eol, data, (t % 32) == 0, (t % 8) == 7);
            end
            if (t == 32) begin
                checks++;
                if (fcnt !== 16'd1) begin
                    errors++;
                    $display("FAIL solid_fcnt: got %0d, want 1", fcnt);
                end
            end
            if (t == 40) en = 1'b0;
            @(negedge clk);
        end
        checks++;
        if ({valid, busy, fcnt} !== {1'b0, 1'b0, 16'd2}) begin
            errors++;
            $display("FAIL solid_end: valid=%b busy=%b fcnt=%0d, want 0 0 2", valid, busy, fcnt);
        end
    endtask

    task automatic test_checker();
        logic [23:0] exp;
        int x, y;
        do_reset();
        mode = 2'd3; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int t = 0; t < 32; t++) begin
            x = t % 8; y = t / 8;
            exp = ((((x >> 1) ^ (y >> 1)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            checks++;
            if (!valid || data !== exp) begin
                errors++;
                $display("FAIL checker x=%0d y=%0d: valid=%b data=%h, want 1 %h", x, y, valid, data, exp);
            end
            @(negedge clk);
        end
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL checker_end: valid=%b, want 0", valid);
        end
    endtask

    task automatic test_backpressure();
        int t = 0, cyc = 0, x;
        logic stalled = 1'b0, r;
        logic [23:0] pd, exp;
        logic ps, pe;
        do_reset();
        mode = 2'd2; en = 1'b1;
        @(negedge clk);
        wait_valid("bp");
        while (t < 32 && cyc < 500) begin
            if (stalled) begin
                checks++;
                if ({valid, data, sof, eol} !== {1'b1, pd, ps, pe}) begin
                    errors++;
                    $display("FAIL bp_stall t=%0d: valid=%b data=%h sof=%b eol=%b, want 1 %h %b %b",
                             t, valid, data, sof, eol, pd, ps, pe);
                end
            end
            x = t % 8;
            exp = {3{8'(x)}};
            checks++;
            if ({valid, sof, eol, data} !== {1'b1, t == 0, x == 7, exp}) begin
                errors++;
                $display("FAIL bp_pixel t=%0d: valid=%b sof=%b eol=%b data=%h, want 1 %b %b %h",
                         t, valid, sof, eol, data, t == 0, x == 7, exp);
            end
            r = 1'($urandom_range(0, 1));
            ready = r;
            if (t >= 10) en = 1'b0;
            stalled = !r;
            pd = data; ps = sof; pe = eol;
            if (r) t++;
            @(negedge clk);
            cyc++;
        end
        ready = 1'b1;
        checks++;
        if (t != 32) begin
            errors++;
            $display("FAIL bp_timeout: transfers=%0d, want 32", t);
        end
        checks++;
        if ({valid, busy, fcnt} !== {1'b0, 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL bp_end: valid=%b busy=%b fcnt=%0d, want 0 0 1", valid, busy, fcnt);
        end
    endtask

    task automatic test_mode_change();
        logic [23:0] exp;
        int x;
        do_reset();
        mode = 2'd0; color = 24'h112233; ready = 1'b1; en = 1'b1;
        @(negedge clk);
        wait_valid("mc");
        for (int t = 0; t < 40; t++) begin
            if (t == 5) mode = 2'd3;
            x = t % 8;
            if (t < 32) exp = 24'h112233;
            else exp = (((x >> 1) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            checks++;
            if (!valid || data !== exp) begin
                errors++;
                $display("FAIL mode_change t=%0d: valid=%b data=%h, want 1 %h", t, valid, data, exp);
            end
            @(negedge clk);
        end
        checks++;
        if (fcnt !== 16'd1) begin
            errors++;
            $display("FAIL mc_fcnt: got %0d, want 1", fcnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({valid, busy, sof, fcnt} !== {3'b000, 16'd0}) begin
            errors++;
            $display("FAIL async_reset: valid=%b busy=%b sof=%b fcnt=%0d, want 0 0 0 0", valid, busy, sof, fcnt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid, sof, fcnt} !== {2'b11, 16'd0}) begin
            errors++;
            $display("FAIL post_reset: valid=%b sof=%b fcnt=%0d, want 1 1 0", valid, sof, fcnt);
        end
        en = 1'b0;
    endtask

    task automatic test_bars();
        logic [23:0] bars [8];
        int b;
        bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
        bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
        do_reset();
        en16 = 1'b1; en19 = 1'b1;
        @(negedge clk);
        en16 = 1'b0; en19 = 1'b0;
        for (int x = 0; x < 19; x++) begin
            b = (x / 2 > 7) ? 7 : x / 2;
            if (x < 16) begin
                checks++;
                if (!v16 || d16 !== bars[b]) begin
                    errors++;
                    $display("FAIL bars16 x=%0d: valid=%b data=%h, want 1 %h", x, v16, d16, bars[b]);
                end
            end
            checks++;
            if (!v19 || d19 !== bars[b]) begin
                errors++;
                $display("FAIL bars19 x=%0d: valid=%b data=%h, want 1 %h", x, v19, d19, bars[b]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ramp();
        logic [23:0] exp;
        do_reset();
        en300 = 1'b1;
        @(negedge clk);
        en300 = 1'b0;
        for (int x = 0; x < 300; x++) begin
            if (x == 0 || x == 255 || x == 256 || x == 299) begin
                case (x)
                    0:       exp = 24'h000000;
                    255:     exp = 24'hFFFFFF;
                    256:     exp = 24'h000000;
                    default: exp = 24'h2B2B2B;
                endcase
                checks++;
                if (!v300 || d300 !== exp || e300 !== (x == 299)) begin
                    errors++;
                    $display("FAIL ramp x=%0d: valid=%b data=%h eol=%b, want 1 %h %b",
                             x, v300, d300, e300, exp, x == 299);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_solid();
        test_checker();
        test_backpressure();
        test_mode_change();
        test_bars();
        test_ramp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Parametrised video test-pattern source for the HDMI stream input (`i_data`/`i_valid`/`o_ready`/`i_sof`/`i_eol` of the HDMI wrapper).
- Replaces the constant-colour stimulus with selectable, frame-synchronous patterns at configurable resolution and colour depth.
- Emits one pixel per accepted handshake, with start-of-frame and end-of-line markers.
- Sits in the pixel clock domain directly upstream of the HDMI wrapper.

Parameters:
H_ACTIVE, 640, active pixels per line (>=8)
V_ACTIVE, 480, active lines per frame (>=2)
BPC, 8, bits per colour channel; data width is 3*BPC, packed {R,G,B}
CHECK_SHIFT, 5, checkerboard square size is 2^CHECK_SHIFT pixels
FCNT_W, 16, frame counter width

Ports:
i_clk_pixel  in  1  pixel clock
i_rst  in  1  asynchronous, active-high reset
i_enable  in  1  run request; sampled at frame boundaries
i_mode  in  2  0 solid, 1 colour bars, 2 grey ramp, 3 checkerboard
i_color  in  3*BPC  solid colour for mode 0
o_data  out  3*BPC  pixel {R,G,B}
o_valid  out  1  pixel valid
i_ready  in  1  sink ready
o_sof  out  1  qualifies first pixel of frame (x=0,y=0)
o_eol  out  1  qualifies last pixel of each line (x=H_ACTIVE-1)
o_busy  out  1  frame in progress
o_frame_cnt  out  FCNT_W  completed-frame count

Behaviour:
- Reset (async assert, sync release): all outputs 0; x=y=0; state IDLE.
- Handshake:
  - Transfer occurs when o_valid && i_ready.
  - While o_valid=1 && i_ready=0, o_data/o_sof/o_eol hold stable and o_valid stays high.
  - o_valid never drops mid-frame except through reset.
- FSM:
  - IDLE: o_valid=0, o_busy=0. If i_enable=1, latch i_mode and i_color into frame registers, load pixel (0,0), go to RUN. o_valid=1 and o_sof=1 on the next cycle (1-cycle latency).
  - RUN: on each transfer, x++. At x=H_ACTIVE-1, x wraps to 0 and y++. Transfer of (H_ACTIVE-1, V_ACTIVE-1) is end of frame: o_frame_cnt++ (wraps at 2^FCNT_W).
  - At end of frame with i_enable=1: relatch mode/colour and present (0,0) with o_sof on the next cycle. Frames run back-to-back with no bubble beyond the handshake.
  - At end of frame with i_enable=0: go to IDLE with o_valid=0 the next cycle.
- Dropping i_enable mid-frame does not truncate the frame; the current frame completes.
- Changing i_mode or i_color mid-frame has no effect until the next frame boundary.
- Pattern computation is registered: the next pixel is precomputed so o_data updates in the same cycle as the transfer advances. No combinational path from i_ready to o_data.
- Mode 0: o_data = latched colour.
- Mode 1, 8 vertical bars:
  - Bar width BW = H_ACTIVE/8 (integer). Last bar absorbs the remainder; bar index saturates at 7.
  - Bar index is tracked by a counter reset at x=0; no divider in the datapath.
  - Order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or 0.
- Mode 2: every channel = x[BPC-1:0]; the ramp wraps every 2^BPC pixels.
- Mode 3: pixel is white if (x>>CHECK_SHIFT)^(y>>CHECK_SHIFT) has LSB 1, else black.
- o_sof=1 only with pixel (0,0). o_eol=1 only when x=H_ACTIVE-1. In a 1-pixel-wide corner case both can never coincide, since H_ACTIVE>=8.
- Reset mid-frame: immediate return to IDLE, counters and o_frame_cnt cleared. The sink must treat the next o_sof as a fresh frame.

Test Plan:
- H_ACTIVE=8, V_ACTIVE=4, mode 0, i_color=24'h112233, i_ready=1, i_enable held 1 -> 32 transfers of 24'h112233. o_sof on transfer 0 and 32; o_eol on transfers 7,15,23,31; o_frame_cnt=1 after transfer 31; no gap between frames.
- H_ACTIVE=16, mode 1 -> x=0,1 FFFFFF; x=2,3 FFFF00; x=4,5 00FFFF; … x=14,15 000000. H_ACTIVE=19 -> bar 7 (000000) covers x=14..18.
- Mode 2, H_ACTIVE=300, BPC=8 -> o_data=24'h000000 at x=0, 24'hFFFFFF at x=255, 24'h000000 at x=256, 24'h2B2B2B at x=299.
- Mode 3, CHECK_SHIFT=1, 8x4 -> row 0: 000000,000000,FFFFFF,FFFFFF,…; row 2 inverted relative to row 0.
- Random i_ready backpressure (50%) -> o_data/o_sof/o_eol stable while stalled, pixel sequence identical to the i_ready=1 run. i_enable dropped at pixel 10 -> frame completes all 32 pixels, then o_valid=0, o_busy=0.
- i_mode changed 0->3 mid-frame -> current frame stays solid, next frame is checkerboard. i_rst pulsed mid-frame -> o_valid=0 and o_frame_cnt=0 asynchronously; after release with i_enable=1 the first pixel carries o_sof.
